// File: rtl/uart_sensor_cmd_ctrl.sv
// Command sequencer between the UART receiver, the SR04 ranging block and the UART transmitter.
// Decodes 'R'/'C'/'S', runs single or periodic measurements and streams "ddd\r\n" or "ERR\r\n".

module uart_sensor_cmd_ctrl #(
  parameter int unsigned PERIOD_CYC  = 10_000_000,
  parameter int unsigned TIMEOUT_CYC = 3_000_000,
  parameter int unsigned CNT_W       = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       sensor_start,
  input  logic       sensor_done,
  input  logic [8:0] sensor_dist,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       busy,
  output logic       cont_mode
);

  localparam logic [7:0]       CmdRead     = 8'h52;
  localparam logic [7:0]       CmdCont     = 8'h43;
  localparam logic [7:0]       CmdStop     = 8'h53;
  localparam logic [CNT_W-1:0] PeriodLast  = CNT_W'(PERIOD_CYC - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [39:0]      ErrFrame    = 40'h45_52_52_0D_0A;

  typedef enum logic [2:0] {
    StIdle,
    StTrig,
    StWait,
    StConv,
    StSend,
    StTxh,
    StTxl
  } state_e;

  state_e           state_q, state_d;
  logic             cont_q, cont_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [8:0]       rem_q, rem_d;
  logic [3:0]       hund_q, hund_d;
  logic [3:0]       tens_q, tens_d;
  logic [39:0]      frame_q, frame_d;
  logic [2:0]       idx_q, idx_d;
  logic             sensor_start_q, sensor_start_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;

  logic             cmd_read, cmd_cont, cmd_stop;
  logic [CNT_W-1:0] period_cnt_inc;

  assign cmd_read       = rx_done && (rx_data == CmdRead);
  assign cmd_cont       = rx_done && (rx_data == CmdCont);
  assign cmd_stop       = rx_done && (rx_data == CmdStop);
  assign period_cnt_inc = period_cnt_q + CNT_W'(1);

  always_comb begin
    state_d        = state_q;
    cont_d         = cont_q;
    pend_d         = pend_q;
    period_cnt_d   = period_cnt_q;
    tmo_cnt_d      = tmo_cnt_q;
    rem_d          = rem_q;
    hund_d         = hund_q;
    tens_d         = tens_q;
    frame_d        = frame_q;
    idx_d          = idx_q;
    sensor_start_d = 1'b0;
    tx_start_d     = 1'b0;
    tx_data_d      = tx_data_q;

    // Period counter saturates at its last value; pend holds the expiry until a trigger consumes it.
    if (!cont_q) begin
      period_cnt_d = '0;
    end else if (period_cnt_q != PeriodLast) begin
      period_cnt_d = period_cnt_inc;
      if (period_cnt_inc == PeriodLast) begin
        pend_d = 1'b1;
      end
    end

    if (cmd_cont) begin
      cont_d = 1'b1;
    end
    if (cmd_stop) begin
      cont_d = 1'b0;
      pend_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (!cmd_stop && (cmd_read || cmd_cont || pend_q)) begin
          state_d      = StTrig;
          period_cnt_d = '0;
          pend_d       = 1'b0;
        end
      end

      StTrig: begin
        sensor_start_d = 1'b1;
        tmo_cnt_d      = '0;
        state_d        = StWait;
      end

      StWait: begin
        // A done arriving on the timeout cycle still counts as a valid measurement.
        if (sensor_done) begin
          rem_d   = sensor_dist;
          hund_d  = '0;
          tens_d  = '0;
          state_d = StConv;
        end else if (tmo_cnt_q == TimeoutLast) begin
          frame_d = ErrFrame;
          idx_d   = '0;
          state_d = StSend;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
      end

      StConv: begin
        if (rem_q >= 9'd100) begin
          rem_d  = rem_q - 9'd100;
          hund_d = hund_q + 4'd1;
        end else if (rem_q >= 9'd10) begin
          rem_d  = rem_q - 9'd10;
          tens_d = tens_q + 4'd1;
        end else begin
          frame_d = {8'h30 + {4'h0, hund_q}, 8'h30 + {4'h0, tens_q}, 8'h30 + {4'h0, rem_q[3:0]},
                     8'h0D, 8'h0A};
          idx_d   = '0;
          state_d = StSend;
        end
      end

      StSend: begin
        if (!tx_busy) begin
          tx_data_d  = frame_q[39:32];
          tx_start_d = 1'b1;
          state_d    = StTxh;
        end
      end

      StTxh: begin
        if (tx_busy) begin
          state_d = StTxl;
        end
      end

      StTxl: begin
        if (!tx_busy) begin
          if (idx_q == 3'd4) begin
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 3'd1;
            frame_d = {frame_q[31:0], 8'h00};
            state_d = StSend;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      cont_q         <= 1'b0;
      pend_q         <= 1'b0;
      period_cnt_q   <= '0;
      tmo_cnt_q      <= '0;
      rem_q          <= '0;
      hund_q         <= '0;
      tens_q         <= '0;
      frame_q        <= '0;
      idx_q          <= '0;
      sensor_start_q <= 1'b0;
      tx_start_q     <= 1'b0;
      tx_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      cont_q         <= cont_d;
      pend_q         <= pend_d;
      period_cnt_q   <= period_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
      rem_q          <= rem_d;
      hund_q         <= hund_d;
      tens_q         <= tens_d;
      frame_q        <= frame_d;
      idx_q          <= idx_d;
      sensor_start_q <= sensor_start_d;
      tx_start_q     <= tx_start_d;
      tx_data_q      <= tx_data_d;
    end
  end

  assign sensor_start = sensor_start_q;
  assign tx_start     = tx_start_q;
  assign tx_data      = tx_data_q;
  assign busy         = (state_q != StIdle);
  assign cont_mode    = cont_q;

endmodule

// File: tb/tb_uart_sensor_cmd_ctrl.sv
// Randomized self-checking bench for uart_sensor_cmd_ctrl with behavioural sensor and
// transmitter models and an arithmetic reference for the reply frames.

module tb_uart_sensor_cmd_ctrl;

  localparam int unsigned PERIOD  = 2000;
  localparam int unsigned TIMEOUT = 500;
  localparam logic [7:0]  CmdR    = 8'h52;
  localparam logic [7:0]  CmdC    = 8'h43;
  localparam logic [7:0]  CmdS    = 8'h53;
  localparam logic [39:0] ErrFrame = 40'h45_52_52_0D_0A;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       sensor_start;
  logic       sensor_done;
  logic [8:0] sensor_dist;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       busy;
  logic       cont_mode;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int stab_err = 0;
  int proto_err = 0;
  int tx_done_cnt = 0;

  logic [7:0] tx_q[$];
  int         tx_cyc_q[$];
  int         start_cyc_q[$];
  int         done_cyc_q[$];
  int         fall_cyc_q[$];

  bit         sens_en = 1'b0;
  int         sens_delay = 1;
  logic [8:0] sens_dist = '0;
  int         tx_hold = 2;

  logic prev_ss = 1'b0;
  logic prev_ts = 1'b0;
  logic prev_busy = 1'b0;

  uart_sensor_cmd_ctrl #(
    .PERIOD_CYC (PERIOD),
    .TIMEOUT_CYC(TIMEOUT),
    .CNT_W      (24)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .sensor_start(sensor_start),
    .sensor_done (sensor_done),
    .sensor_dist (sensor_dist),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .busy        (busy),
    .cont_mode   (cont_mode)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder and pulse-protocol monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (sensor_start) start_cyc_q.push_back(cyc);
    if (prev_busy && !busy) fall_cyc_q.push_back(cyc);
    if (!rst && ((sensor_start && tx_start) || (sensor_start && prev_ss) || (tx_start && prev_ts)))
      proto_err <= proto_err + 1;
    prev_ss   <= sensor_start;
    prev_ts   <= tx_start;
    prev_busy <= busy;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Transmitter model: busy rises one cycle after tx_start and stays high tx_hold cycles.
  initial begin : xmit
    logic [7:0] b;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        b = tx_data;
        tx_q.push_back(b);
        tx_cyc_q.push_back(cyc);
        @(negedge clk);
        tx_busy = 1'b1;
        repeat (tx_hold) @(negedge clk);
        if (tx_data !== b) stab_err++;
        tx_busy = 1'b0;
        tx_done_cnt++;
      end
    end
  end

  // Ranging block model: answers each trigger after sens_delay cycles when enabled.
  initial begin : sensor
    sensor_done = 1'b0;
    sensor_dist = '0;
    forever begin
      @(negedge clk);
      if (sensor_start && sens_en) begin
        repeat (sens_delay) @(negedge clk);
        sensor_dist = sens_dist;
        sensor_done = 1'b1;
        done_cyc_q.push_back(cyc);
        @(negedge clk);
        sensor_done = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #950000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [39:0] exp_frame(input int d);
    logic [7:0] h, t, o;
    h = 8'(8'h30 + d / 100);
    t = 8'(8'h30 + (d / 10) % 10);
    o = 8'(8'h30 + d % 10);
    return {h, t, o, 8'h0D, 8'h0A};
  endfunction

  task automatic clear_logs();
    tx_q.delete();
    tx_cyc_q.delete();
    start_cyc_q.delete();
    done_cyc_q.delete();
    fall_cyc_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, output int c0);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    c0 = cyc;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while ((busy || tx_busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_idle_in_time"}, (k < budget), 1);
  endtask

  task automatic wait_starts(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (start_cyc_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_starts_in_time"}, (k < budget), 1);
  endtask

  task automatic check_frame(input string tag, input int base, input logic [39:0] exp);
    check_eq({tag, "_have_frame"}, (tx_q.size() >= base + 5), 1);
    for (int i = 0; i < 5; i++) begin
      logic [7:0] got;
      got = (base + i < tx_q.size()) ? tx_q[base + i] : 8'h00;
      check_eq($sformatf("%s_b%0d", tag, i), got, exp[39 - 8 * i -: 8]);
    end
  endtask

  task automatic single_meas(input string tag, input int d, input int dly, input int hold);
    int c0, lat;
    clear_logs();
    sens_en    = 1'b1;
    sens_delay = dly;
    sens_dist  = 9'(d);
    tx_hold    = hold;
    send_byte(CmdR, c0);
    wait_idle(tag, 3000);
    check_eq({tag, "_starts"}, start_cyc_q.size(), 1);
    lat = (start_cyc_q.size() > 0) ? start_cyc_q[0] - c0 : -1;
    check_eq({tag, "_start_lat"}, lat, 2);
    lat = (tx_cyc_q.size() > 0 && done_cyc_q.size() > 0) ? tx_cyc_q[0] - done_cyc_q[0] : 999;
    check_eq({tag, "_conv_lat_ok"}, (lat > 0 && lat <= 17), 1);
    check_eq({tag, "_nbytes"}, tx_q.size(), 5);
    check_frame(tag, 0, exp_frame(d));
    check_eq({tag, "_busy_low"}, busy, 0);
  endtask

  initial begin : main
    int c0, lat, d5, base, k;
    rst     = 1'b1;
    rx_data = '0;
    rx_done = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_sensor_start", sensor_start, 0);
    check_eq("rst_tx_start", tx_start, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_cont_mode", cont_mode, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single measurement, then randomized distances, delays and transmitter speeds.
    single_meas("t1", 123, 100, 2);
    for (int n = 0; n < 6; n++)
      single_meas($sformatf("rnd%0d", n), $urandom_range(0, 511), $urandom_range(1, 400),
                  $urandom_range(1, 20));
    single_meas("d0", 0, 5, 2);
    single_meas("d511", 511, 5, 2);
    single_meas("d7", 7, 5, 2);

    // Timeout path and a late done that must be ignored.
    clear_logs();
    sens_en = 1'b0;
    tx_hold = 2;
    send_byte(CmdR, c0);
    wait_idle("t2", 2000);
    check_eq("t2_starts", start_cyc_q.size(), 1);
    lat = (tx_cyc_q.size() > 0 && start_cyc_q.size() > 0) ? tx_cyc_q[0] - start_cyc_q[0] : -1;
    check_eq("t2_timeout_lat_ok", (lat >= TIMEOUT && lat <= TIMEOUT + 3), 1);
    check_frame("t2_err", 0, ErrFrame);
    @(negedge clk);
    sensor_dist = 9'd77;
    sensor_done = 1'b1;
    @(negedge clk);
    sensor_done = 1'b0;
    repeat (50) @(negedge clk);
    check_eq("t2_late_done_nbytes", tx_q.size(), 5);
    check_eq("t2_late_done_starts", start_cyc_q.size(), 1);
    check_eq("t2_late_done_busy", busy, 0);

    // Continuous mode at fixed period, stopped mid-WAIT.
    clear_logs();
    sens_en    = 1'b1;
    sens_delay = 50;
    sens_dist  = 9'd45;
    tx_hold    = 2;
    send_byte(CmdC, c0);
    check_eq("t4_cont_on", cont_mode, 1);
    wait_starts("t4", 3, 7000);
    lat = (start_cyc_q.size() > 0) ? start_cyc_q[0] - c0 : -1;
    check_eq("t4_first_lat", lat, 2);
    lat = (start_cyc_q.size() > 1) ? start_cyc_q[1] - start_cyc_q[0] : -1;
    check_eq("t4_spacing1", lat, PERIOD);
    lat = (start_cyc_q.size() > 2) ? start_cyc_q[2] - start_cyc_q[1] : -1;
    check_eq("t4_spacing2", lat, PERIOD);
    repeat (10) @(negedge clk);
    send_byte(CmdS, c0);
    check_eq("t4_cont_off", cont_mode, 0);
    wait_idle("t4", 1000);
    repeat (2500) @(negedge clk);
    check_eq("t4_starts_after_stop", start_cyc_q.size(), 3);
    check_eq("t4_nbytes", tx_q.size(), 15);
    for (int f = 0; f < 3; f++) check_frame($sformatf("t4_f%0d", f), 5 * f, exp_frame(45));

    // Continuous mode with a slow transmitter: pending triggers fire right after return to idle.
    clear_logs();
    d5         = $urandom_range(0, 511);
    sens_delay = 20;
    sens_dist  = 9'(d5);
    tx_hold    = 3000;
    send_byte(CmdC, c0);
    wait_starts("t5a", 2, 20000);
    repeat (100) @(negedge clk);
    send_byte(CmdR, c0);
    wait_starts("t5b", 3, 20000);
    tx_hold = 2;
    send_byte(CmdS, c0);
    wait_idle("t5", 5000);
    repeat (2500) @(negedge clk);
    check_eq("t5_starts", start_cyc_q.size(), 3);
    lat = (fall_cyc_q.size() > 0 && start_cyc_q.size() > 1) ? start_cyc_q[1] - fall_cyc_q[0] : -1;
    check_eq("t5_pend_lat1", lat, 2);
    lat = (fall_cyc_q.size() > 1 && start_cyc_q.size() > 2) ? start_cyc_q[2] - fall_cyc_q[1] : -1;
    check_eq("t5_pend_lat2", lat, 2);
    check_eq("t5_cont_off", cont_mode, 0);
    for (int f = 0; f < 3; f++) check_frame($sformatf("t5_f%0d", f), 5 * f, exp_frame(d5));

    // Reset while the third byte is about to be sent.
    clear_logs();
    sens_delay = 30;
    sens_dist  = 9'd200;
    tx_hold    = 2;
    base       = tx_done_cnt;
    send_byte(CmdR, c0);
    k = 0;
    while (tx_done_cnt < base + 2 && k < 2000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_eq("t6_reach_byte2", (k < 2000), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("t6_sensor_start", sensor_start, 0);
    check_eq("t6_tx_start", tx_start, 0);
    check_eq("t6_tx_data", tx_data, 0);
    check_eq("t6_busy", busy, 0);
    check_eq("t6_cont_mode", cont_mode, 0);
    repeat (100) @(negedge clk);
    check_eq("t6_no_more_tx", tx_q.size(), 2);
    check_eq("t6_no_more_start", start_cyc_q.size(), 1);
    single_meas("t6_after", $urandom_range(0, 511), 40, 2);

    check_eq("tx_data_stable", stab_err, 0);
    check_eq("pulse_protocol", proto_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
